// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bundle for the sequential binary-to-BCD converter.
// The converter is the slave; a producer/consumer pair (or bench) uses master.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [BIN_W-1:0]        in_bin;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*DIGITS-1:0]     out_bcd;
    logic [NDIG_W-1:0]       out_ndig;

    modport slave (
        input  in_valid,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_ndig
    );

    modport master (
        output in_valid,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_ndig
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides and a significant-digit count output.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned NDIG_W = $clog2(DIGITS + 1);
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned ACC_W  = 4 * DIGITS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

    generate
        if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
            $error("bin_to_bcd_seq: BIN_W must be in 1..32");
        end
        if (DIGITS < 1 || DIGITS > 10 || pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     shreg_q, shreg_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     out_bcd_q, out_bcd_d;
    logic [NDIG_W-1:0]    out_ndig_q, out_ndig_d;

    logic [ACC_W-1:0]       adj;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic [NDIG_W-1:0]      nd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_bcd_q  <= '0;
            out_ndig_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_bcd_q  <= out_bcd_d;
            out_ndig_q <= out_ndig_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_bcd_d  = out_bcd_q;
        out_ndig_d = out_ndig_q;

        // Add-3 correction before the shift keeps each digit in 0..9 afterwards.
        adj = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end else begin
                adj[4*k +: 4] = acc_q[4*k +: 4];
            end
        end
        shifted = {adj, shreg_q} << 1;

        nd = NDIG_W'(1);
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (shifted[BIN_W + 4*k +: 4] != 4'd0) begin
                nd = NDIG_W'(k + 1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d = bus.in_bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = shifted[ACC_W+BIN_W-1:BIN_W];
                shreg_d = shifted[BIN_W-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_bcd_d  = shifted[ACC_W+BIN_W-1:BIN_W];
                    out_ndig_d = nd;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ndig  = out_ndig_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default 8-bit/3-digit and 16-bit/5-digit instances,
// table vectors, queue scoreboard, and hand-written backpressure/reset sequences.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] bcd;
        logic [2:0]  ndig;
    } exp_t;

    typedef struct {
        int unsigned v;
        logic [19:0] bcd;
        logic [2:0]  ndig;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];

    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) a_if ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) b_if ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by div/mod, significant digits from the top non-zero one.
    function automatic exp_t model(input int unsigned v);
        exp_t e;
        int unsigned t;
        t = v;
        e.bcd  = '0;
        e.ndig = 3'd1;
        for (int k = 0; k < 5; k++) begin
            e.bcd[4*k +: 4] = 4'(t % 10);
            if (t % 10 != 0) e.ndig = 3'(k + 1);
            t = t / 10;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_bcd", 64'(a_if.out_bcd), 64'(e.bcd[11:0]));
                check("a_ndig", 64'(a_if.out_ndig), 64'(e.ndig));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_if.out_valid && b_if.out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_bcd", 64'(b_if.out_bcd), 64'(e.bcd));
                check("b_ndig", 64'(b_if.out_ndig), 64'(e.ndig));
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_a(input int unsigned v, input exp_t e, input bit push);
        bit ok;
        ok = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_bin   = 8'(v);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("a_accept_timeout", 64'd0, 64'd1);
            a_if.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) qa.push_back(e);
            #1;
            a_if.in_valid = 1'b0;
            a_if.in_bin   = 8'($urandom);
        end
    endtask

    task automatic send_b(input int unsigned v, input exp_t e, input bit push);
        bit ok;
        ok = 1'b0;
        b_if.in_valid = 1'b1;
        b_if.in_bin   = 16'(v);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("b_accept_timeout", 64'd0, 64'd1);
            b_if.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) qb.push_back(e);
            #1;
            b_if.in_valid = 1'b0;
            b_if.in_bin   = 16'($urandom);
        end
    endtask

    // Counts negedges with out_valid low before the first one with it high.
    task automatic wait_valid_a(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (a_if.out_valid) break;
            n++;
        end
    endtask

    task automatic wait_valid_b(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_if.out_valid) break;
            n++;
        end
    endtask

    task automatic drain_a();
        for (int i = 0; i < 2000; i++) begin
            if (qa.size() == 0) break;
            @(negedge clk);
        end
        check("a_drain", 64'(qa.size()), 64'd0);
        tick();
    endtask

    task automatic drain_b();
        for (int i = 0; i < 2000; i++) begin
            if (qb.size() == 0) break;
            @(negedge clk);
        end
        check("b_drain", 64'(qb.size()), 64'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        exp_t e;
        int   n;
        int   hi;
        bit   sweep_on;

        tbl[0] = '{v: 0,   bcd: 20'h00000, ndig: 3'd1};
        tbl[1] = '{v: 255, bcd: 20'h00255, ndig: 3'd3};
        tbl[2] = '{v: 100, bcd: 20'h00100, ndig: 3'd3};
        tbl[3] = '{v: 9,   bcd: 20'h00009, ndig: 3'd1};
        tbl[4] = '{v: 10,  bcd: 20'h00010, ndig: 3'd2};
        tbl[5] = '{v: 99,  bcd: 20'h00099, ndig: 3'd2};
        tbl[6] = '{v: 1,   bcd: 20'h00001, ndig: 3'd1};
        tbl[7] = '{v: 200, bcd: 20'h00200, ndig: 3'd3};

        rst_n = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_bin = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_bin = '0; b_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(a_if.in_ready), 64'd1);
        check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst_out_bcd", 64'(a_if.out_bcd), 64'd0);
        check("rst_out_ndig", 64'(a_if.out_ndig), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First conversion: latency and value of zero.
        e = '{bcd: 20'h00000, ndig: 3'd1};
        send_a(0, e, 1'b1);
        wait_valid_a(n);
        check("a_latency", 64'(n), 64'd8);
        tick();
        a_if.out_ready = 1'b1;
        drain_a();

        foreach (tbl[i]) begin
            e = '{bcd: tbl[i].bcd, ndig: tbl[i].ndig};
            send_a(tbl[i].v, e, 1'b1);
        end
        drain_a();

        // out_ready already high: out_valid must last exactly one cycle.
        e = '{bcd: 20'h00009, ndig: 3'd1};
        send_a(9, e, 1'b1);
        hi = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (a_if.out_valid) hi++;
        end
        check("a_valid_one_cycle", 64'(hi), 64'd1);
        drain_a();

        // Backpressure with a competing in_valid that must be ignored.
        a_if.out_ready = 1'b0;
        e = '{bcd: 20'h00173, ndig: 3'd3};
        send_a(173, e, 1'b1);
        wait_valid_a(n);
        check("a_latency_173", 64'(n), 64'd8);
        tick();
        a_if.in_valid = 1'b1;
        a_if.in_bin   = 8'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_bcd", 64'(a_if.out_bcd), 64'h173);
            check("bp_ndig", 64'(a_if.out_ndig), 64'd3);
            check("bp_valid", 64'(a_if.out_valid), 64'd1);
            check("bp_in_ready", 64'(a_if.in_ready), 64'd0);
        end
        tick();
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(a_if.in_ready), 64'd1);
        check("bp_release_valid", 64'(a_if.out_valid), 64'd0);
        check("bp_hold_bcd", 64'(a_if.out_bcd), 64'h173);
        check("a_drain_bp", 64'(qa.size()), 64'd0);
        tick();

        // Reset during the fourth SHIFT cycle abandons the conversion.
        send_a(200, e, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_if.out_valid), 64'd0);
        check("mid_rst_bcd", 64'(a_if.out_bcd), 64'd0);
        check("mid_rst_ndig", 64'(a_if.out_ndig), 64'd0);
        check("mid_rst_in_ready", 64'(a_if.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        check("mid_rst_valid_held", 64'(a_if.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        e = '{bcd: 20'h00042, ndig: 3'd2};
        send_a(42, e, 1'b1);
        drain_a();

        // Sweep with random gaps and random consumer readiness.
        sweep_on = 1'b1;
        fork
            begin
                while (sweep_on) begin
                    @(posedge clk);
                    #1;
                    a_if.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_a(v, model(v), 1'b1);
        end
        drain_a();
        sweep_on = 1'b0;
        tick();
        tick();
        a_if.out_ready = 1'b1;
        tick();

        // Wide instance.
        e = '{bcd: 20'h65535, ndig: 3'd5};
        send_b(65535, e, 1'b1);
        wait_valid_b(n);
        check("b_latency", 64'(n), 64'd16);
        tick();
        b_if.out_ready = 1'b1;
        drain_b();
        e = '{bcd: 20'h01000, ndig: 3'd4};
        send_b(1000, e, 1'b1);
        drain_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
